dmem_responder: RTL and testbench

Data-memory responder for the 5-stage pipeline: the memory side of the MEM-stage load/store interface. It accepts address, store data, access size and read/write strobes, performs the access on an internal word-organised RAM with byte-lane selection, and returns load data right-justified and zero-extended. The MEM stage sign-extends that data. A configurable wait-state counter and a `ready` stall signal let the pipeline model slow memory.

---
 rtl/dmem_responder.sv | 159 +++++++++++++++
 tb/tb_dmem_responder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with byte lanes, wait states and ready stall.
// Optional misaligned-access checking is enabled by defining DMEM_MISALIGN_CHK_EN.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] address,
    input  logic [31:0] data_write,
    input  logic [1:0]  size,
    input  logic        mem_write,
    input  logic        mem_read,
    output logic [31:0] data_mem,
    output logic        ready,
    output logic        misalign
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] dm_q, dm_d;

    logic [31:0] ram_q [0:(1<<ADDR_WIDTH)-1];

    logic                  req;
    logic [ADDR_WIDTH-1:0] widx;
    logic [1:0]            lane;
    logic                  is_byte, is_half;
    logic [3:0]            be;
    logic [31:0]           wdata_al;
    logic [31:0]           rword, rdata;
    logic                  mis;
    logic                  commit;
    logic                  wr_en;
    logic                  unused_hi;

    assign req     = mem_read | mem_write;
    assign widx    = address[ADDR_WIDTH+1:2];
    assign lane    = address[1:0];
    assign is_byte = (size == 2'b10);
    assign is_half = (size == 2'b01);
    assign unused_hi = ^address[31:ADDR_WIDTH+2];

`ifdef DMEM_MISALIGN_CHK_EN
    assign mis = (is_half & address[0])
               | (~is_half & ~is_byte & (lane != 2'b00));
`else
    assign mis = 1'b0;
`endif

    // Store data is replicated across lanes; byte enables pick the target.
    always_comb begin
        be       = 4'b1111;
        wdata_al = data_write;
        unique case (1'b1)
            is_byte: begin
                be       = 4'b0001 << lane;
                wdata_al = {4{data_write[7:0]}};
            end
            is_half: begin
                be       = address[1] ? 4'b1100 : 4'b0011;
                wdata_al = {2{data_write[15:0]}};
            end
            default: begin
                be       = 4'b1111;
                wdata_al = data_write;
            end
        endcase
    end

    assign rword = ram_q[widx];

    always_comb begin
        rdata = rword;
        unique case (1'b1)
            is_byte: rdata = {24'b0, rword[{lane, 3'b000} +: 8]};
            is_half: rdata = {16'b0, rword[{address[1], 4'b0000} +: 16]};
            default: rdata = rword;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES == 0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign commit = (state_d == S_DONE) && (state_q != S_DONE);
    assign wr_en  = commit & mem_write & ~mis;
    assign ready  = (state_q == S_DONE) | ((state_q == S_IDLE) & ~req);

    always_comb begin
        dm_d = dm_q;
        if (commit) begin
            if (mis) dm_d = 32'b0;
            else if (mem_read & ~mem_write) dm_d = rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            dm_q    <= 32'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dm_q    <= dm_d;
        end
    end

    // RAM is not reset; an asserted reset still blocks a pending write.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) ram_q[widx][8*b +: 8] <= wdata_al[8*b +: 8];
            end
        end
    end

    assign data_mem = dm_q;

`ifdef DMEM_MISALIGN_CHK_EN
    logic mis_q, mis_d;

    always_comb begin
        mis_d = mis_q;
        if (commit) mis_d = mis;
        else if (state_q == S_DONE) mis_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mis_q <= 1'b0;
        else        mis_q <= mis_d;
    end

    assign misalign = mis_q;
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed plan steps plus random accesses
// checked against a word-array reference model (WAIT_STATES 2 and 0).
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] addr_s [2];
    logic [31:0] wd_s   [2];
    logic [1:0]  sz_s   [2];
    logic        we_s   [2];
    logic        re_s   [2];
    logic [31:0] dm_s   [2];
    logic        rdy_s  [2];
    logic        mis_s  [2];

    int checks   = 0;
    int failures = 0;

    logic [31:0] mdl    [2][1024];
    logic [31:0] exp_dm [2];

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .rst_n(rst_n),
        .address(addr_s[0]), .data_write(wd_s[0]), .size(sz_s[0]),
        .mem_write(we_s[0]), .mem_read(re_s[0]),
        .data_mem(dm_s[0]), .ready(rdy_s[0]), .misalign(mis_s[0])
    );

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst_n(rst_n),
        .address(addr_s[1]), .data_write(wd_s[1]), .size(sz_s[1]),
        .mem_write(we_s[1]), .mem_read(re_s[1]),
        .data_mem(dm_s[1]), .ready(rdy_s[1]), .misalign(mis_s[1])
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_mis(logic [1:0] sz, logic [31:0] a);
`ifdef DMEM_MISALIGN_CHK_EN
        if (sz == 2'b01) return a[0];
        if (sz == 2'b10) return 1'b0;
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] mdl_read(logic [31:0] w, logic [1:0] sz,
                                             logic [31:0] a);
        if (sz == 2'b10) return (w >> (8 * a[1:0])) & 32'hFF;
        if (sz == 2'b01) return (w >> (16 * a[1])) & 32'hFFFF;
        return w;
    endfunction

    function automatic logic [31:0] mdl_write(logic [31:0] w, logic [1:0] sz,
                                              logic [31:0] a, logic [31:0] d);
        logic [31:0] mask;
        int sh;
        if (sz == 2'b10) begin
            sh = 8 * a[1:0];
            mask = 32'hFF << sh;
            return (w & ~mask) | ((d & 32'hFF) << sh);
        end
        if (sz == 2'b01) begin
            sh = 16 * a[1];
            mask = 32'hFFFF << sh;
            return (w & ~mask) | ((d & 32'hFFFF) << sh);
        end
        return d;
    endfunction

    task automatic access(int s, bit we, bit re, logic [1:0] sz,
                          logic [31:0] a, logic [31:0] wd, string tag);
        int ws;
        int lat;
        bit m;
        logic [9:0] wi;
        ws = (s == 0) ? 2 : 0;
        @(posedge clk); #1;
        addr_s[s] = a; wd_s[s] = wd; sz_s[s] = sz;
        we_s[s] = we; re_s[s] = re;
        lat = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rdy_s[s] === 1'b1) begin
                lat = c;
                break;
            end
        end
        m  = is_mis(sz, a);
        wi = a[11:2];
        if (we) begin
            if (m) exp_dm[s] = 32'b0;
            else   mdl[s][wi] = mdl_write(mdl[s][wi], sz, a, wd);
        end else if (re) begin
            exp_dm[s] = m ? 32'b0 : mdl_read(mdl[s][wi], sz, a);
        end
        chk({tag, ".lat"}, lat, 1 + ws);
        chk({tag, ".dm"}, dm_s[s], exp_dm[s]);
        chk({tag, ".mis"}, {31'b0, mis_s[s]}, {31'b0, m});
        @(posedge clk); #1;
        we_s[s] = 1'b0; re_s[s] = 1'b0;
        @(negedge clk);
        chk({tag, ".idle"}, {31'b0, rdy_s[s]}, 32'd1);
        chk({tag, ".misclr"}, {31'b0, mis_s[s]}, 32'd0);
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            addr_s[s] = '0; wd_s[s] = '0; sz_s[s] = '0;
            we_s[s] = 1'b0; re_s[s] = 1'b0;
            exp_dm[s] = '0;
        end
        #2;
        chk("rst.ready", {31'b0, rdy_s[0]}, 32'd1);
        chk("rst.dm", dm_s[0], 32'd0);
        chk("rst.mis", {31'b0, mis_s[0]}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        access(0, 1, 0, 2'b00, 32'h10, 32'hDEADBEEF, "w10");
        access(0, 0, 1, 2'b00, 32'h10, 32'h0, "r10");
        access(0, 1, 0, 2'b10, 32'h13, 32'h000000A5, "wb13");
        access(0, 0, 1, 2'b00, 32'h10, 32'h0, "r10b");
        access(0, 0, 1, 2'b10, 32'h13, 32'h0, "rb13");
        access(0, 1, 0, 2'b01, 32'h12, 32'h00001234, "wh12");
        access(0, 0, 1, 2'b00, 32'h10, 32'h0, "r10h");
        access(0, 0, 1, 2'b01, 32'h12, 32'h0, "rh12");
        access(0, 1, 1, 2'b00, 32'h10, 32'h0, "both10");
        access(0, 0, 1, 2'b00, 32'h10, 32'h0, "r10z");
        access(0, 0, 1, 2'b10, 32'h13, 32'h0, "rb13z");
        access(0, 1, 0, 2'b01, 32'h11, 32'h0000FFFF, "wh11");
        access(0, 0, 1, 2'b00, 32'h10, 32'h0, "r10m");

        access(1, 1, 0, 2'b00, 32'h10, 32'hCAFEF00D, "b.w10");
        access(1, 0, 1, 2'b00, 32'h10, 32'h0, "b.r10");
        access(1, 1, 1, 2'b00, 32'h10, 32'h0, "b.both");
        access(1, 0, 1, 2'b00, 32'h10, 32'h0, "b.r10z");

        access(0, 1, 0, 2'b00, 32'h20, 32'h0BADF00D, "w20");
        access(0, 0, 1, 2'b00, 32'h20, 32'h0, "r20");
        @(posedge clk); #1;
        addr_s[0] = 32'h20; wd_s[0] = 32'h55555555; sz_s[0] = 2'b00;
        we_s[0] = 1'b1; re_s[0] = 1'b0;
        @(posedge clk); #1;
        chk("abort.wait", {31'b0, rdy_s[0]}, 32'd0);
        rst_n = 1'b0;
        #1;
        we_s[0] = 1'b0;
        #2;
        rst_n = 1'b1;
        exp_dm[0] = 32'b0;
        exp_dm[1] = 32'b0;
        @(negedge clk);
        chk("abort.ready", {31'b0, rdy_s[0]}, 32'd1);
        chk("abort.dm", dm_s[0], 32'd0);
        chk("abort.dm0", dm_s[1], 32'd0);
        chk("abort.mis", {31'b0, mis_s[0]}, 32'd0);
        access(0, 0, 1, 2'b00, 32'h20, 32'h0, "abort.r20");

        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 16; i++) begin
                access(s, 1, 0, 2'b00, 32'h100 + 4 * i, $urandom, "init");
            end
        end
        for (int i = 0; i < 60; i++) begin
            int s;
            int kind;
            logic [31:0] a;
            s    = $urandom_range(0, 1);
            kind = $urandom_range(0, 2);
            a    = (32'h100 + $urandom_range(0, 63)) | ($urandom & 32'hFFFFF000);
            access(s, kind != 0, kind != 1, 2'($urandom_range(0, 3)), a,
                   $urandom, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
